// File: rtl/hash_pkg.sv
// hash_pkg: cover-length encodings, multiplicative hash primes and raw-window alignment
// shared by the multi-lane hash stage.
package hash_pkg;
  localparam logic [1:0] COVER_4B = 2'b00;
  localparam logic [1:0] COVER_5B = 2'b01;
  localparam logic [1:0] COVER_6B = 2'b10;
  localparam logic [63:0] PRIME4 = 64'h9E3779B1;
  localparam logic [63:0] PRIME5 = 64'hCF1BBCDCBB;
  localparam logic [63:0] PRIME6 = 64'hCF1BBCDCBF9B;
  // 4B is placed at bit 32 so its 32-bit product appears in the top word of a 64-bit multiply
  function automatic logic [63:0] left_justify(input logic [47:0] w, input logic [1:0] sel);
    return sel == COVER_4B ? {w[31:0], 32'b0} : sel == COVER_6B ? {w, 16'b0} : {w[39:0], 24'b0};
  endfunction
  function automatic logic [63:0] cover_prime(input logic [1:0] sel);
    return sel == COVER_4B ? PRIME4 : sel == COVER_6B ? PRIME6 : PRIME5;
  endfunction
endpackage

// File: rtl/hash_lane_mul.sv
// hash_lane_mul: one lane's 64-bit multiplicative hash from 32x32 partial products
// (hi*hi dropped, only the top word is kept), registered over MUL_STAGES stages.
module hash_lane_mul
  import hash_pkg::*;
#(
  parameter int MUL_STAGES = 2,
  parameter int HASH_BITS  = 15
) (
  input  logic                  clk,
  input  logic [MUL_STAGES-1:0] en,
  input  logic [47:0]           win,
  input  logic [1:0]            cover_sel,
  output logic [HASH_BITS-1:0]  hash
);
  localparam int D = MUL_STAGES > 1 ? MUL_STAGES - 1 : 1;
  localparam int O = MUL_STAGES > 1 ? 1 : 0;
  logic [63:0] raw, prime;
  logic [31:0] ll_hi, xs;
  logic [HASH_BITS-1:0] h_q [D];
  assign raw   = left_justify(win, cover_sel);
  assign prime = cover_prime(cover_sel);
  assign ll_hi = 32'((64'(raw[31:0]) * 64'(prime[31:0])) >> 32);
  assign xs    = raw[63:32] * prime[31:0] + raw[31:0] * prime[63:32];
  generate
    if (MUL_STAGES == 1) begin : g_one
      always_ff @(posedge clk)
        if (en[0]) h_q[0] <= HASH_BITS'((ll_hi + xs) >> (32 - HASH_BITS));
    end else begin : g_two
      logic [31:0] ll_q, xs_q;
      always_ff @(posedge clk) begin
        if (en[0]) begin
          ll_q <= ll_hi;
          xs_q <= xs;
        end
        if (en[1]) h_q[0] <= HASH_BITS'((ll_q + xs_q) >> (32 - HASH_BITS));
      end
    end
    for (genvar s = 1; s < D; s++) begin : g_dly
      always_ff @(posedge clk)
        if (en[s+O]) h_q[s] <= h_q[s-1];
    end
  endgenerate
  assign hash = h_q[D-1];
endmodule

// File: rtl/hash_compute_mlane.sv
// hash_compute_mlane: LANES parallel multiplicative hashes per beat, bubble-squeezing
// pipeline into a 2-entry skid buffer. Define HASH_COMPUTE_STATS_EN to add stat counters.
module hash_compute_mlane
  import hash_pkg::*;
#(
  parameter int LANES      = 16,
  parameter int ADDR_W     = 32,
  parameter int HASH_BITS  = 15,
  parameter int MAX_COVER  = 6,
  parameter int MUL_STAGES = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [ADDR_W-1:0]              in_head_addr,
  input  logic [(LANES+MAX_COVER-1)*8-1:0] in_data,
  input  logic [LANES-1:0]               in_lane_mask,
  input  logic [1:0]                     in_cover_sel,
  input  logic                           in_delim,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ADDR_W-1:0]              out_head_addr,
  output logic [HASH_BITS*LANES-1:0]     out_hash_vec,
  output logic [LANES-1:0]               out_lane_mask,
  output logic                           out_delim
`ifdef HASH_COMPUTE_STATS_EN
  ,
  output logic [31:0]                    stat_beats,
  output logic [31:0]                    stat_hashes,
  output logic [31:0]                    stat_stall_cycles
`endif
);
  localparam int SBW = ADDR_W + LANES + 1;
  localparam int CAP = MUL_STAGES + 2;
  logic acc, pop, push, nxt, wp, rp;
  logic [MUL_STAGES-1:0] v, inv, ld, adv, en;
  logic [SBW-1:0] sb_in [MUL_STAGES];
  logic [SBW-1:0] sb_q [MUL_STAGES];
  logic [SBW-1:0] sb_m [2];
  logic [HASH_BITS*LANES-1:0] hv_m [2];
  logic [HASH_BITS*LANES-1:0] hv_in;
  logic [HASH_BITS-1:0] h [LANES];
  logic [1:0] sc;
  logic [3:0] tot, tot_n;
  assign acc       = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign push      = adv[MUL_STAGES-1];
  assign out_valid = sc != 2'd0;
  assign {out_head_addr, out_lane_mask, out_delim} = sb_m[rp];
  assign out_hash_vec = hv_m[rp];
  assign tot_n = tot + 4'(acc) - 4'(pop);
  // a stage moves whenever anything downstream has room, so empty stages never stall
  always_comb begin
    adv = '0;
    ld = '0;
    inv = '0;
    nxt = sc != 2'd2 || pop;
    for (int s = MUL_STAGES - 1; s >= 0; s--) begin
      adv[s] = v[s] && nxt;
      ld[s] = !v[s] || adv[s];
      nxt = ld[s];
    end
    inv[0] = acc;
    sb_in[0] = {in_head_addr, in_lane_mask, in_delim};
    for (int s = 1; s < MUL_STAGES; s++) begin
      inv[s] = v[s-1];
      sb_in[s] = sb_q[s-1];
    end
    en = ld & inv;
  end
  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      hash_lane_mul #(.MUL_STAGES(MUL_STAGES), .HASH_BITS(HASH_BITS)) u_mul (
        .clk(clk), .en(en), .win(in_data[i*8 +: 48]), .cover_sel(in_cover_sel), .hash(h[i])
      );
      assign hv_in[i*HASH_BITS +: HASH_BITS] = sb_q[MUL_STAGES-1][1+i] ? h[i] : '0;
    end
  endgenerate
  // in_ready looks at next-cycle occupancy so an accepted beat always has a slot
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v <= '0;
      sc <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      tot <= '0;
      in_ready <= 1'b0;
    end else begin
      v <= (v & ~ld) | (inv & ld);
      sc <= sc + 2'(push) - 2'(pop);
      wp <= wp ^ push;
      rp <= rp ^ pop;
      tot <= tot_n;
      in_ready <= tot_n < 4'(CAP);
    end
  always_ff @(posedge clk) begin
    for (int s = 0; s < MUL_STAGES; s++)
      if (en[s]) sb_q[s] <= sb_in[s];
    if (push) begin
      hv_m[wp] <= hv_in;
      sb_m[wp] <= sb_q[MUL_STAGES-1];
    end
  end
  always_ff @(posedge clk)
    if (acc) assert (in_cover_sel != 2'b11);
`ifdef HASH_COMPUTE_STATS_EN
  logic [32:0] hs_n;
  assign hs_n = 33'(stat_hashes) + 33'($countones(in_lane_mask));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stat_beats <= '0;
      stat_hashes <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (acc && !(&stat_beats)) stat_beats <= stat_beats + 32'd1;
      if (acc) stat_hashes <= hs_n[32] ? '1 : hs_n[31:0];
      if (out_valid && !out_ready && !(&stat_stall_cycles)) stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
`endif
endmodule

// File: tb/tb_hash_compute_mlane.sv
// tb_hash_compute_mlane: random and directed beats checked against an arithmetic
// hash model and an in-order expectation queue.
module tb_hash_compute_mlane;
  localparam int LANES = 16, HB = 15, AW = 32, DW = (LANES + 5) * 8;
  logic clk = 0, rst = 1;
  logic in_valid, in_ready, in_delim, out_valid, out_ready, out_delim;
  logic [AW-1:0] in_head_addr, out_head_addr;
  logic [DW-1:0] in_data;
  logic [LANES-1:0] in_lane_mask, out_lane_mask;
  logic [1:0] in_cover_sel;
  logic [HB*LANES-1:0] out_hash_vec;
`ifdef HASH_COMPUTE_STATS_EN
  logic [31:0] stat_beats, stat_hashes, stat_stall_cycles;
`endif
  always #5 clk = ~clk;

  hash_compute_mlane dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_head_addr(in_head_addr), .in_data(in_data), .in_lane_mask(in_lane_mask),
    .in_cover_sel(in_cover_sel), .in_delim(in_delim), .out_valid(out_valid),
    .out_ready(out_ready), .out_head_addr(out_head_addr), .out_hash_vec(out_hash_vec),
    .out_lane_mask(out_lane_mask), .out_delim(out_delim)
`ifdef HASH_COMPUTE_STATS_EN
    , .stat_beats(stat_beats), .stat_hashes(stat_hashes), .stat_stall_cycles(stat_stall_cycles)
`endif
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [HB*LANES-1:0] hv;
    logic [LANES-1:0] mask;
    logic delim;
  } beat_t;
  beat_t q[$];
  int n_chk = 0, n_fail = 0, n_push = 0, n_pop = 0, n_stall = 0;
  bit chk_rdy = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [HB-1:0] ref_hash(input logic [DW-1:0] d, input int i, input logic [1:0] sel);
    int n;
    logic [63:0] w, p;
    logic [31:0] p4;
    n = sel == 2'd0 ? 4 : sel == 2'd2 ? 6 : 5;
    w = '0;
    for (int k = 0; k < n; k++) w[k*8 +: 8] = d[(i+k)*8 +: 8];
    if (n == 4) begin
      p4 = w[31:0] * 32'h9E3779B1;
      return p4[31 -: HB];
    end
    p = (w << (64 - 8 * n)) * (n == 5 ? 64'hCF1BBCDCBB : 64'hCF1BBCDCBF9B);
    return p[63 -: HB];
  endfunction

  function automatic logic [HB*LANES-1:0] ref_vec(input logic [DW-1:0] d, input logic [LANES-1:0] m, input logic [1:0] sel);
    logic [HB*LANES-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) if (m[i]) r[i*HB +: HB] = ref_hash(d, i, sel);
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [191:0] t;
    for (int k = 0; k < 6; k++) t[k*32 +: 32] = $urandom;
    return t[DW-1:0];
  endfunction

  always @(negedge clk) begin
    beat_t e;
    if (!rst) begin
      if (chk_rdy) check("in_ready_vs_held", in_ready, q.size() < 4);
      if (out_valid && !out_ready) n_stall++;
      if (out_valid && out_ready) begin
        check("out_has_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("out_addr", out_head_addr, e.addr);
          check("out_hash_vec", out_hash_vec, e.hv);
          check("out_mask", out_lane_mask, e.mask);
          check("out_delim", out_delim, e.delim);
        end
        n_pop++;
      end
      if (in_valid && in_ready) begin
        e.addr = in_head_addr;
        e.hv = ref_vec(in_data, in_lane_mask, in_cover_sel);
        e.mask = in_lane_mask;
        e.delim = in_delim;
        q.push_back(e);
        n_push++;
      end
    end
  end

  task automatic set_beat(input logic [1:0] sel, input logic [DW-1:0] d, input logic [LANES-1:0] m, input logic dl);
    in_valid = 1;
    in_cover_sel = sel;
    in_data = d;
    in_lane_mask = m;
    in_delim = dl;
    in_head_addr = $urandom;
  endtask

  task automatic send_lat(input logic [1:0] sel, input logic [DW-1:0] d, input logic [LANES-1:0] m, input logic dl, output int lat);
    @(posedge clk); #1;
    set_beat(sel, d, m, dl);
    @(negedge clk);
    check("accept_ready", in_ready, 1);
    lat = 0;
    do begin
      @(posedge clk); #1;
      in_valid = 0;
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 20);
  endtask

  task automatic drain();
    out_ready = 1;
    for (int c = 0; c < 50 && q.size() != 0; c++) begin @(negedge clk); #1; end
    check("drain_empty", q.size(), 0);
    check("push_eq_pop", n_pop, n_push);
  endtask

  task automatic rand_traffic(input int nbeats, input bit fixed_mask);
    bit done = 0;
    int sent = 0;
    fork
      begin
        while (sent < nbeats) begin
          @(posedge clk); #1;
          in_valid = 0;
          if ($urandom_range(0, 9) < 8)
            set_beat(2'($urandom_range(0, 2)), rand_data(), fixed_mask ? 16'h000F : 16'($urandom), 1'($urandom));
          @(negedge clk);
          if (in_valid && in_ready) sent++;
        end
        @(posedge clk); #1;
        in_valid = 0;
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = $urandom_range(0, 9) >= 3;
        end
      end
    join
    drain();
  endtask

  task automatic hard_reset();
    chk_rdy = 0;
    @(posedge clk); #1;
    in_valid = 0;
    rst = 1;
    q.delete();
    n_push = 0; n_pop = 0; n_stall = 0;
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    check("ready_after_rst", in_ready, 1);
    chk_rdy = 1;
  endtask

  initial begin
    int lat;
    logic [DW-1:0] d;
    logic [HB*LANES-1:0] outside;
    in_valid = 0; out_ready = 1; in_data = '0; in_lane_mask = '0;
    in_cover_sel = 2'd0; in_delim = 0; in_head_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    rst = 0;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);
    chk_rdy = 1;

    d = '0;
    d[7:0] = 8'h01;
    send_lat(2'b01, d, '1, 0, lat);
    check("lat_5b", lat, 3);
    check("hash_5b_lane0", out_hash_vec[HB-1:0], 15'h678D);
    send_lat(2'b00, d, '1, 0, lat);
    check("lat_4b", lat, 3);
    check("hash_4b_lane0", out_hash_vec[HB-1:0], 15'h4F1B);
    for (int s = 0; s < 3; s++) begin
      send_lat(2'(s), '0, '1, 0, lat);
      check("zero_data_hash", out_hash_vec, 0);
    end

    send_lat(2'b10, rand_data(), 16'h00F0, 1, lat);
    for (int i = 0; i < LANES; i++) outside[i*HB +: HB] = (i >= 4 && i < 8) ? '0 : '1;
    check("mask_pass", out_lane_mask, 16'h00F0);
    check("delim_set", out_delim, 1);
    check("masked_lanes_zero", out_hash_vec & outside, 0);
    send_lat(2'b01, rand_data(), '1, 0, lat);
    check("delim_clear", out_delim, 0);

    rand_traffic(100, 0);

    @(posedge clk); #1;
    out_ready = 0;
    set_beat(2'b00, rand_data(), '1, 0);
    @(posedge clk); #1;
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    check("squeeze_held", out_valid, 1);
    for (int b = 0; b < 3; b++) begin
      repeat (2) @(posedge clk);
      #1;
      set_beat(2'($urandom_range(0, 2)), rand_data(), 16'($urandom), 0);
      @(negedge clk);
      check("squeeze_accept", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 0;
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("squeeze_full", in_ready, 0);
    @(posedge clk); #1;
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("b2b_out_valid", out_valid, 1);
    end
    drain();

    out_ready = 0;
    for (int b = 0; b < 3; b++) begin
      @(posedge clk); #1;
      set_beat(2'($urandom_range(0, 2)), rand_data(), '1, 0);
    end
    @(posedge clk); #1;
    in_valid = 0;
    check("pre_rst_valid", out_valid, 1);
    chk_rdy = 0;
    rst = 1;
    #1;
    check("rst_async_drop", out_valid, 0);
    q.delete();
    n_push = 0; n_pop = 0; n_stall = 0;
    out_ready = 1;
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    check("ready_after_midrst", in_ready, 1);
    chk_rdy = 1;
    d = rand_data();
    send_lat(2'b10, d, '1, 0, lat);
    check("lat_after_rst", lat, 3);
    check("hash_after_rst", out_hash_vec, ref_vec(d, '1, 2'b10));
    drain();

`ifdef HASH_COMPUTE_STATS_EN
    hard_reset();
    rand_traffic(10, 1);
    @(negedge clk);
    check("stat_beats", stat_beats, 10);
    check("stat_hashes", stat_hashes, 40);
    check("stat_stall", stat_stall_cycles, n_stall);
`else
    hard_reset();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation timeout");
  end
endmodule

// File: doc/hash_compute_mlane.md
Name: hash_compute_mlane

Overview:
- Parametrised successor to the single-mode hash stage in the hash engine. Sits between the input window slicer and the hash-table access stage.
- Each beat computes LANES multiplicative hashes, one per byte offset, from an input byte window.
- Cover length is selectable per beat (4/5/6 bytes), with a matching prime per cover length.
- Per-lane valid mask; pipeline that squeezes out bubbles; 2-entry skid buffer so input_ready is a registered signal.

Parameters:
- LANES, 16, hashes per beat (lane i hashes window bytes i .. i+cover-1)
- ADDR_W, 32, head address width
- HASH_BITS, 15, hash output width; legal range 8..31
- MAX_COVER, 6, window bytes reserved per lane; fixed at 6
- MUL_STAGES, 2, multiplier pipeline depth; legal range 1..4

Ports:
- clk  in  1  clock
- rst  in  1  reset: asynchronous assert, active-high, clears all valid state
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_head_addr  in  ADDR_W  address of lane 0
- in_data  in  (LANES+MAX_COVER-1)*8  window bytes; byte k = in_data[k*8+:8]
- in_lane_mask  in  LANES  1 = lane hash required
- in_cover_sel  in  2  00 = 4B, 01 = 5B, 10 = 6B, 11 = reserved (treated as 5B)
- in_delim  in  1  last beat of block
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_head_addr  out  ADDR_W  passthrough of in_head_addr
- out_hash_vec  out  HASH_BITS*LANES  lane i = out_hash_vec[i*HASH_BITS+:HASH_BITS]
- out_lane_mask  out  LANES  passthrough; masked lanes output 0
- out_delim  out  1  passthrough of in_delim

Behaviour:
- Reset values: out_valid=0, in_ready=1 one cycle after rst deasserts. All stage valids and skid entries are cleared. Data registers are not reset.
- Window w_i = in_data[i*8 +: cover*8]; the lowest-addressed byte is the least significant byte.
- 4B mode: 32-bit product, p = w_i * 32'h9E3779B1 mod 2^32; hash = p[31 -: HASH_BITS].
- 5B mode: raw = {w_i, 24'b0}; p = raw * 64'hCF1BBCDCBB mod 2^64; hash = p[63 -: HASH_BITS].
- 6B mode: raw = {w_i, 16'b0}; p = raw * 64'hCF1BBCDCBF9B mod 2^64; hash = p[63 -: HASH_BITS].
- Multiply: built from 32x32 partial products (hi*hi term dropped), split across MUL_STAGES registered stages.
- cover_sel, mask, addr and delim travel in lockstep with their beat.
- Pipeline flow:
  - Each stage s has valid v[s].
  - Stage s loads when !v[s+1] or stage s+1 advances.
  - The last stage feeds the skid buffer.
  - Empty stages do not block; no global stall.
- Skid buffer, 2 entries:
  - in_ready = registered "buffer occupancy + in-flight valid beats < 2 + MUL_STAGES", i.e. total capacity never overrun.
  - out_valid = buffer non-empty. Output data comes from the head entry.
  - Simultaneous push and pop when full: legal, occupancy unchanged.
  - Pop when empty: impossible.
- Latency: in accept to out_valid = MUL_STAGES+1 cycles (3 at default) with out_ready held high.
- Throughput: 1 beat/cycle sustained while out_ready=1.
- out_ready low: beats accumulate until all stages and both entries are full, then in_ready drops. No beat is lost or duplicated; order is preserved.
- in_lane_mask = 0: the beat still flows; out_hash_vec = 0.
- Reset mid-operation: all in-flight beats are discarded; out_valid falls asynchronously.
- cover_sel = 11: hashed as 5B. An assertion fires in simulation.

Optional Feature:
- Macro HASH_COMPUTE_STATS_EN.
- When defined, adds outputs:
  - stat_beats (32 bits): accepted beats.
  - stat_hashes (32 bits): popcount of masks of accepted beats.
  - stat_stall_cycles (32 bits): cycles with out_valid && !out_ready.
- Counters saturate at all-ones and are cleared by rst.
- When undefined, these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package hash_pkg holds:
  - cover_sel encoding constants COVER_4B / COVER_5B / COVER_6B.
  - Constants PRIME4 / PRIME5 / PRIME6.
  - Function for left-justified raw construction.
- Sub-module hash_lane_mul: one lane, pipelined multiply. Parameters MUL_STAGES and HASH_BITS; it receives cover_sel and the advance enable.
- Skid buffer is inline in the top module.

Test Plan:
- Single-beat hash values (defaults):
  - 5B, lane0 bytes 01 00 00 00 00, mask all ones -> lane0 hash 15'h678D, out_valid 3 cycles after accept.
  - 4B, same bytes -> lane0 hash 15'h4F1B.
  - All-zero data in every mode -> all hashes 0.
- Backpressure: 100 random beats, out_ready toggling randomly (30% low) -> outputs match the reference model in order; no loss or duplication; in_ready low only when 2+MUL_STAGES beats are held.
- Bubble squeeze: out_ready low with one beat held in the skid buffer, in_valid pulsed every 3rd cycle -> later beats advance into empty stages; no bubble in output once out_ready rises (back-to-back out_valid).
- Mask and delim passthrough: mask 16'h00F0, delim 1 -> out_lane_mask 16'h00F0, lanes outside the mask 0, out_delim 1 on that beat only.
- Reset mid-flight: assert rst with 3 beats in flight -> out_valid 0 immediately; after release, a fresh beat produces a correct result with latency 3.
- Stats (HASH_COMPUTE_STATS_EN): 10 beats, each mask 16'h000F -> stat_beats 10, stat_hashes 40; stat_stall_cycles equals the number of cycles with out_valid && !out_ready.
